// File: rtl/ntt_stage_sequencer_pkg.sv
// NTT stage sequencer shared definitions.
// State encodings, default geometry and a width helper.
package ntt_stage_sequencer_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int DEF_LOG_N  = 12;
  localparam int DEF_BF_LAT = 7;
  localparam int DEF_RD_LAT = 1;

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ntt_stage_sequencer_delay_line.sv
// Fixed-depth shift register with async clear.
// Carries read strobe/addresses forward to the write port.
module ntt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Radix-2 CT NTT sequencer: per-stage address issue,
// pipeline drain between stages, delayed write-back.
module ntt_stage_sequencer
  import ntt_stage_sequencer_pkg::*;
#(
  parameter int LOG_N  = DEF_LOG_N,
  parameter int BF_LAT = DEF_BF_LAT,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [clog2_min1(LOG_N)-1:0]  stage,
  output logic                          rd_en,
  output logic [LOG_N-1:0]              rd_addr_a,
  output logic [LOG_N-1:0]              rd_addr_b,
  output logic [LOG_N-2:0]              tw_addr,
  output logic                          wr_en,
  output logic [LOG_N-1:0]              wr_addr_a,
  output logic [LOG_N-1:0]              wr_addr_b
);

  localparam int SW  = clog2_min1(LOG_N);
  localparam int TL  = RD_LAT + BF_LAT;
  localparam int KW  = LOG_N - 1;
  localparam int DW  = clog2_min1(TL);
  localparam int DLW = 2 * LOG_N + 1;

  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
  localparam logic [DW-1:0] D_LOAD = DW'(TL - 1);

  logic [1:0]       state, nstate;
  logic [KW-1:0]    k, nk;
  logic [SW-1:0]    nstg;
  logic [DW-1:0]    dcnt, ndcnt;
  logic             ndone;
  logic             issue_nx;

  logic [LOG_N-1:0] kx, m, i_idx, a_nx, b_nx;
  logic [KW-1:0]    tw_nx;
  int               sh;

  always_comb begin
    nstate = state;
    nk     = k;
    nstg   = stage;
    ndcnt  = dcnt;
    ndone  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nstate = S_ISSUE;
          nk     = '0;
          nstg   = '0;
        end
      end
      S_ISSUE: begin
        if (k == K_LAST) begin
          nstate = S_DRAIN;
          nk     = '0;
          ndcnt  = D_LOAD;
        end else begin
          nk = k + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt == '0) begin
          if (stage == S_LAST) begin
            nstate = S_IDLE;
            ndone  = 1'b1;
          end else begin
            nstate = S_ISSUE;
            nstg   = stage + 1'b1;
          end
        end else begin
          ndcnt = dcnt - 1'b1;
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Addresses are computed from the next k/stage so they register alongside rd_en.
  always_comb begin
    sh    = int'(nstg);
    kx    = LOG_N'(nk);
    m     = LOG_N'(1) << sh;
    i_idx = kx & (m - LOG_N'(1));
    a_nx  = ((kx >> sh) << (sh + 1)) | i_idx;
    b_nx  = a_nx | m;
    tw_nx = KW'(i_idx << (LOG_N - 1 - sh));
  end

  assign issue_nx = (nstate == S_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      stage     <= '0;
      dcnt      <= '0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state     <= nstate;
      k         <= nk;
      stage     <= nstg;
      dcnt      <= ndcnt;
      done      <= ndone;
      rd_en     <= issue_nx;
      rd_addr_a <= issue_nx ? a_nx : '0;
      rd_addr_b <= issue_nx ? b_nx : '0;
      tw_addr   <= issue_nx ? tw_nx : '0;
    end
  end

  assign busy = (state != S_IDLE);

  logic [DLW-1:0] dly_out;

  ntt_delay_line #(
    .WIDTH (DLW),
    .DEPTH (TL)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_en, rd_addr_a, rd_addr_b}),
    .dout (dly_out)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = dly_out;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: address/timing checks at LOG_N=3,
// data scoreboard against a direct-DFT golden at LOG_N=3 and 5.
module tb_ntt_stage_sequencer;

  localparam int Q = 7681;

  logic clk = 1'b0;
  logic rst;
  logic start3, start5;
  always #5 clk = ~clk;

  logic       busy3, done3, rd_en3, wr_en3;
  logic [1:0] stage3, tw3;
  logic [2:0] ra3, rb3, wa3, wb3;

  logic       busy5, done5, rd_en5, wr_en5;
  logic [2:0] stage5;
  logic [3:0] tw5;
  logic [4:0] ra5, rb5, wa5, wb5;

  ntt_stage_sequencer #(.LOG_N(3), .BF_LAT(7), .RD_LAT(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .stage(stage3), .rd_en(rd_en3), .rd_addr_a(ra3), .rd_addr_b(rb3),
    .tw_addr(tw3), .wr_en(wr_en3), .wr_addr_a(wa3), .wr_addr_b(wb3));

  ntt_stage_sequencer #(.LOG_N(5), .BF_LAT(7), .RD_LAT(1)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5),
    .stage(stage5), .rd_en(rd_en5), .rd_addr_a(ra5), .rd_addr_b(rb5),
    .tw_addr(tw5), .wr_en(wr_en5), .wr_addr_a(wa5), .wr_addr_b(wb5));

  logic       sel5;
  logic       done_g, rd_en_g, wr_en_g;
  logic [4:0] ra_g, rb_g, wa_g, wb_g;
  logic [3:0] tw_g;

  always_comb begin
    done_g  = sel5 ? done5  : done3;
    rd_en_g = sel5 ? rd_en5 : rd_en3;
    wr_en_g = sel5 ? wr_en5 : wr_en3;
    ra_g    = sel5 ? ra5 : {2'b00, ra3};
    rb_g    = sel5 ? rb5 : {2'b00, rb3};
    wa_g    = sel5 ? wa5 : {2'b00, wa3};
    wb_g    = sel5 ? wb5 : {2'b00, wb3};
    tw_g    = sel5 ? tw5 : {2'b00, tw3};
  end

  int nchk = 0;
  int nfail = 0;

  typedef struct { int cyc; int a; int b; int tw; int stg; } rd_t;
  typedef struct { int cyc; int a; int b; int va; int vb; } bf_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int powmod(input int b, input int e);
    longint r, bb;
    int ee;
    r = 1; bb = b; ee = e;
    while (ee > 0) begin
      if (ee[0]) r = (r * bb) % Q;
      bb = (bb * bb) % Q;
      ee = ee >> 1;
    end
    return int'(r);
  endfunction

  function automatic int bitrev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++)
      if (v[i]) r = r | (1 << (bits - 1 - i));
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1; start3 = 1'b0; start5 = 1'b0; sel5 = 1'b0;
    tick;
    nchk++;
    if ({busy3, done3, rd_en3, wr_en3} !== 4'b0) begin
      nfail++;
      $display("FAIL reset_ctl3 got %b want 0000", {busy3, done3, rd_en3, wr_en3});
    end
    nchk++;
    if ({stage3, ra3, rb3, tw3, wa3, wb3} !== 16'h0) begin
      nfail++;
      $display("FAIL reset_addr3 got %h want 0", {stage3, ra3, rb3, tw3, wa3, wb3});
    end
    nchk++;
    if ({busy5, done5, rd_en5, wr_en5, stage5, ra5, rb5, tw5} !== 21'h0) begin
      nfail++;
      $display("FAIL reset_dut5 got %h want 0",
               {busy5, done5, rd_en5, wr_en5, stage5, ra5, rb5, tw5});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_sequence;
    int pa [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int pb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int pt [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    rd_t rq[$];
    rd_t wq[$];
    rd_t e;
    for (int n = 0; n < 12; n++) begin
      e.stg = n / 4;
      e.cyc = 1 + e.stg * 12 + (n % 4);
      e.a = pa[n]; e.b = pb[n]; e.tw = pt[n];
      rq.push_back(e);
      e.cyc = e.cyc + 8;
      wq.push_back(e);
    end
    start3 = 1'b1;
    nchk++;
    if (busy3 !== 1'b0 || rd_en3 !== 1'b0) begin
      nfail++;
      $display("FAIL seq_c0 busy=%b rd_en=%b want 0 0", busy3, rd_en3);
    end
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (c == 1) start3 = 1'b0;
      nchk++;
      if (busy3 !== (c >= 1 && c <= 36)) begin
        nfail++;
        $display("FAIL seq_busy c=%0d got %b", c, busy3);
      end
      nchk++;
      if (done3 !== (c == 37)) begin
        nfail++;
        $display("FAIL seq_done c=%0d got %b", c, done3);
      end
      if (rd_en3 === 1'b1) begin
        nchk++;
        if (rq.size() == 0 || rq[0].cyc != c) begin
          nfail++;
          $display("FAIL seq_rd_unexpected c=%0d a=%0d b=%0d", c, ra3, rb3);
        end else begin
          e = rq.pop_front();
          if (ra3 !== 3'(e.a) || rb3 !== 3'(e.b) || tw3 !== 2'(e.tw) ||
              stage3 !== 2'(e.stg)) begin
            nfail++;
            $display("FAIL seq_rd c=%0d got s%0d (%0d,%0d) tw%0d want s%0d (%0d,%0d) tw%0d",
                     c, stage3, ra3, rb3, tw3, e.stg, e.a, e.b, e.tw);
          end
        end
      end else if (rq.size() != 0 && rq[0].cyc == c) begin
        nchk++; nfail++;
        $display("FAIL seq_rd_missing c=%0d got rd_en=%b want 1", c, rd_en3);
      end
      if (wr_en3 === 1'b1) begin
        nchk++;
        if (wq.size() == 0 || wq[0].cyc != c) begin
          nfail++;
          $display("FAIL seq_wr_unexpected c=%0d a=%0d b=%0d", c, wa3, wb3);
        end else begin
          e = wq.pop_front();
          if (wa3 !== 3'(e.a) || wb3 !== 3'(e.b)) begin
            nfail++;
            $display("FAIL seq_wr c=%0d got (%0d,%0d) want (%0d,%0d)",
                     c, wa3, wb3, e.a, e.b);
          end
        end
      end else if (wq.size() != 0 && wq[0].cyc == c) begin
        nchk++; nfail++;
        $display("FAIL seq_wr_missing c=%0d got wr_en=%b want 1", c, wr_en3);
      end
    end
    nchk++;
    if (rq.size() != 0 || wq.size() != 0) begin
      nfail++;
      $display("FAIL seq_leftover got rd=%0d wr=%0d want 0 0", rq.size(), wq.size());
    end
  endtask

  task automatic test_start_held;
    int rdcnt = 0;
    int dq[$];
    start3 = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick;
      if (c == 38) start3 = 1'b0;
      if (rd_en3 === 1'b1 && c <= 36) rdcnt++;
      if (done3 === 1'b1) dq.push_back(c);
      if (c == 37) begin
        nchk++;
        if (busy3 !== 1'b0) begin
          nfail++;
          $display("FAIL held_busy37 got %b want 0", busy3);
        end
      end
      if (c == 38) begin
        nchk++;
        if (busy3 !== 1'b1 || rd_en3 !== 1'b1) begin
          nfail++;
          $display("FAIL held_restart38 busy=%b rd_en=%b want 1 1", busy3, rd_en3);
        end
      end
    end
    nchk++;
    if (rdcnt != 12) begin
      nfail++;
      $display("FAIL held_reads got %0d want 12", rdcnt);
    end
    nchk++;
    if (dq.size() != 2 || dq[0] != 37 || dq[1] != 74) begin
      nfail++;
      $display("FAIL held_done got n=%0d first=%0d want 2 at 37,74",
               dq.size(), (dq.size() > 0) ? dq[0] : -1);
    end
  endtask

  task automatic test_reset_mid;
    int spur = 0;
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    for (int c = 2; c <= 15; c++) tick;
    rst = 1'b1;
    #1;
    nchk++;
    if ({busy3, rd_en3, wr_en3} !== 3'b000) begin
      nfail++;
      $display("FAIL rstmid_async got busy/rd/wr=%b want 000", {busy3, rd_en3, wr_en3});
    end
    tick;
    rst = 1'b0;
    #1;
    nchk++;
    if (stage3 !== 2'd0) begin
      nfail++;
      $display("FAIL rstmid_stage got %0d want 0", stage3);
    end
    for (int c = 16; c <= 24; c++) begin
      if (wr_en3 !== 1'b0 || busy3 !== 1'b0) spur++;
      tick;
    end
    nchk++;
    if (spur != 0) begin
      nfail++;
      $display("FAIL rstmid_spurious got %0d active cycles want 0", spur);
    end
    test_sequence();
  endtask

  task automatic test_ntt(input int logn);
    int n, w, cand, budget, exp_done, got_done;
    int x[32];
    int gold[32];
    int mem[32];
    int rom[16];
    bf_t pq[$];
    bf_t e;
    longint acc, t;
    n = 1 << logn;
    sel5 = (logn == 5);
    w = 0;
    for (int g = 2; g < 200 && w == 0; g++) begin
      cand = powmod(g, (Q - 1) / n);
      if (powmod(cand, n / 2) != 1) w = cand;
    end
    for (int i = 0; i < n; i++) begin
      x[i] = int'($urandom % Q);
      mem[bitrev(i, logn)] = x[i];
    end
    for (int k = 0; k < n; k++) begin
      acc = 0;
      for (int j = 0; j < n; j++)
        acc = (acc + longint'(x[j]) * powmod(w, (j * k) % n)) % Q;
      gold[k] = int'(acc);
    end
    for (int i = 0; i < n / 2; i++) rom[i] = powmod(w, i);
    exp_done = 1 + logn * (n / 2 + 8);
    budget = exp_done + 10;
    got_done = -1;
    if (sel5) start5 = 1'b1; else start3 = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      tick;
      if (c == 1) begin start3 = 1'b0; start5 = 1'b0; end
      if (rd_en_g === 1'b1) begin
        t = (longint'(rom[tw_g]) * mem[rb_g]) % Q;
        e.cyc = c + 8; e.a = ra_g; e.b = rb_g;
        e.va = int'((mem[ra_g] + t) % Q);
        e.vb = int'((mem[ra_g] + Q - t) % Q);
        pq.push_back(e);
      end
      if (wr_en_g === 1'b1) begin
        nchk++;
        if (pq.size() == 0) begin
          nfail++;
          $display("FAIL ntt%0d_wr_unexpected c=%0d", logn, c);
        end else begin
          e = pq.pop_front();
          if (e.cyc != c || wa_g != 5'(e.a) || wb_g != 5'(e.b)) begin
            nfail++;
            $display("FAIL ntt%0d_wr c=%0d got (%0d,%0d) want c=%0d (%0d,%0d)",
                     logn, c, wa_g, wb_g, e.cyc, e.a, e.b);
          end
          mem[wa_g] = e.va;
          mem[wb_g] = e.vb;
        end
      end
      if (done_g === 1'b1) begin
        got_done = c;
        break;
      end
    end
    nchk++;
    if (got_done != exp_done) begin
      nfail++;
      $display("FAIL ntt%0d_done got cycle %0d want %0d", logn, got_done, exp_done);
    end
    nchk++;
    if (pq.size() != 0) begin
      nfail++;
      $display("FAIL ntt%0d_pending got %0d want 0", logn, pq.size());
    end
    for (int k = 0; k < n; k++) begin
      nchk++;
      if (mem[k] != gold[k]) begin
        nfail++;
        $display("FAIL ntt%0d_coef[%0d] got %0d want %0d", logn, k, mem[k], gold[k]);
      end
    end
    sel5 = 1'b0;
    tick;
  endtask

  initial begin
    test_reset();
    test_sequence();
    tick;
    test_start_held();
    tick;
    test_reset_mid();
    tick;
    test_ntt(3);
    test_ntt(5);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
